countdown_timer: RTL and testbench
==================================

Name: countdown_timer

Overview:
- Loadable down-counting timer; the decrementing counterpart to the team's free-running up counter.
- Software or control logic loads a start value, starts it, can pause and resume it, and receives a one-cycle done pulse at expiry.
- Optional auto-reload mode turns it into a periodic tick generator.
- Used as the timeout and interval source beside the up counters in the same clock domain.

Parameters:
WIDTH, 8, bit width of load value, reload register and count output

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
load  input  1  load request; copies load_val into count and reload register
load_val  input  WIDTH  value taken when load=1
start  input  1  start/resume request
pause  input  1  pause request
auto_reload  input  1  1 = reload from reload register on expiry and keep running; sampled at the expiry edge
count  output  WIDTH  current remaining count
busy  output  1  1 when state is RUN or PAUSED
done  output  1  one-cycle pulse, high in the cycle after an expiry edge

Behaviour:
- Reset (rst=1 at an edge, synchronous):
  - state=IDLE, count=0, reload_reg=0, done=0, busy=0.
  - rst overrides every other input.
- Priority within a cycle: rst > load > start/pause > decrement.
- States: IDLE, RUN, PAUSED. busy is registered and equals (state!=IDLE).
- load=1 (any state):
  - count<=load_val, reload_reg<=load_val, state<=IDLE, done<=0.
  - start and pause are ignored in the same cycle.
- IDLE:
  - start=1 and count!=0: state<=RUN; count is not decremented at this edge.
  - start=1 with count==0: ignored; stays IDLE, no done.
  - pause is ignored.
- RUN:
  - Each edge with no load and no pause: if count>1, count<=count-1.
  - Expiry edge (count==1):
    - auto_reload=0: count<=0, state<=IDLE, done<=1.
    - auto_reload=1: count<=reload_reg, stays RUN, done<=1.
  - Timing: after start at edge N, expiry occurs at edge N+V for loaded value V, and done is high during cycle N+V.
  - Auto-reload period is exactly V cycles between done pulses.
  - pause=1: state<=PAUSED, count holds. This includes the expiry edge: pause wins, count stays 1, no done.
  - start while RUN is ignored.
- PAUSED:
  - Count holds; done=0.
  - start=1: state<=RUN; no decrement at this edge, so decrementing resumes on the next edge.
  - pause alone: no effect. start and pause together: start wins.
- done: registered, high for exactly one cycle per expiry, never high in two consecutive cycles unless V=1 with auto_reload=1.
  - V=1 with auto_reload=1 gives continuous done=1 with count holding at 1. This is legal and defined.
- Arithmetic:
  - Unsigned count.
  - Never wraps below 0: a decrement from 0 cannot occur because RUN is never entered with count==0 and expiry fires at 1.
  - load_val of all-ones is allowed; it gives a (2^WIDTH-1)-cycle timeout.
- Reset mid-RUN: the next cycle shows count=0, IDLE, busy=0, done=0, reload_reg=0.

Test Plan:
1. Reset, then load_val=5/load, start at edge N, auto_reload=0 -> count 5,4,3,2,1,0 across edges N..N+5; done=1 only in cycle N+5; busy falls with count=0.
2. Load 3, auto_reload=1, start -> done pulses every 3 cycles; count cycles 3,2,1,3,2,1; busy stays 1.
3. Load 6, start, pause after 2 decrements (count=4), hold pause 5 cycles, then start -> count frozen at 4 while PAUSED; expiry 4 edges after resume; exactly one done.
4. Load 2, start; pause asserted on the expiry edge (count=1) -> count stays 1, no done, state PAUSED; start -> done next edge.
5. Load 0 then start -> stays IDLE, count=0, busy=0, no done. Then load 7 and start in the same cycle -> count=7, IDLE (load wins).
6. Load 9, start, rst after 3 decrements (count=6) -> next cycle count=0, busy=0, done=0; a following start with no load is ignored (count=0).

Source files
------------

// File: rtl/countdown_timer.sv
// Loadable down-counting timer with pause/resume, expiry pulse
// and optional auto-reload for periodic ticks.
module countdown_timer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             start,
   input  logic             pause,
   input  logic             auto_reload,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      PAUSED
   } state_t;

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   state_t           state, state_nx;
   logic [WIDTH-1:0] count_nx;
   logic [WIDTH-1:0] reload_reg, reload_nx;
   logic             done_nx;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         count      <= '0;
         reload_reg <= '0;
         done       <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state      <= state_nx;
         count      <= count_nx;
         reload_reg <= reload_nx;
         done       <= done_nx;
         busy       <= (state_nx != IDLE);
      end
   end

   always_comb begin
      state_nx  = state;
      count_nx  = count;
      reload_nx = reload_reg;
      done_nx   = 1'b0;
      if (load) begin
         count_nx  = load_val;
         reload_nx = load_val;
         state_nx  = IDLE;
      end else begin
         unique case (state)
            IDLE: begin
               if (start && count != '0)
                  state_nx = RUN;
            end
            RUN: begin
               if (pause) begin
                  state_nx = PAUSED;
               end else if (count > ONE) begin
                  count_nx = count - ONE;
               end else if (count == ONE) begin
                  done_nx = 1'b1;
                  if (auto_reload) begin
                     count_nx = reload_reg;
                  end else begin
                     count_nx = '0;
                     state_nx = IDLE;
                  end
               end else begin
                  // unreachable: RUN is never entered with count==0
                  state_nx = IDLE;
               end
            end
            PAUSED: begin
               if (start)
                  state_nx = RUN;
            end
            default: state_nx = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer.
module tb_countdown_timer;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       load = 1'b0;
   logic [7:0] load_val = '0;
   logic       start = 1'b0;
   logic       pause = 1'b0;
   logic       auto_reload = 1'b0;
   logic [7:0] count;
   logic       busy;
   logic       done;

   int n_chk = 0;
   int n_fail = 0;

   countdown_timer #(.WIDTH(8)) dut (
      .clk(clk),
      .rst(rst),
      .load(load),
      .load_val(load_val),
      .start(start),
      .pause(pause),
      .auto_reload(auto_reload),
      .count(count),
      .busy(busy),
      .done(done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic chk3(input string tag, input int c, input int b, input int d);
      chk({tag, ".count"}, int'(count), c);
      chk({tag, ".busy"}, int'(busy), b);
      chk({tag, ".done"}, int'(done), d);
   endtask

   task automatic do_load(input int v);
      load = 1'b1;
      load_val = 8'(v);
      tick();
      load = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      // 1: reset and one-shot countdown of 5
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk3("t1.reset", 0, 0, 0);
      do_load(5);
      chk3("t1.load", 5, 0, 0);
      do_start();
      chk3("t1.start", 5, 1, 0);
      for (int k = 1; k <= 5; k++) begin
         tick();
         chk3($sformatf("t1.e%0d", k), 5 - k, (k < 5) ? 1 : 0, (k == 5) ? 1 : 0);
      end
      tick();
      chk3("t1.after", 0, 0, 0);

      // 2: auto-reload period 3
      auto_reload = 1'b1;
      do_load(3);
      do_start();
      chk3("t2.start", 3, 1, 0);
      for (int k = 1; k <= 6; k++) begin
         tick();
         chk3($sformatf("t2.e%0d", k), 3 - (k % 3), 1, (k % 3 == 0) ? 1 : 0);
      end
      auto_reload = 1'b0;
      do_load(0);
      chk3("t2.stop", 0, 0, 0);

      // 3: pause mid-count, resume
      do_load(6);
      do_start();
      tick();
      tick();
      chk3("t3.run", 4, 1, 0);
      pause = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         tick();
         chk3($sformatf("t3.p%0d", k), 4, 1, 0);
      end
      pause = 1'b0;
      do_start();
      chk3("t3.resume", 4, 1, 0);
      for (int k = 1; k <= 4; k++) begin
         tick();
         chk3($sformatf("t3.e%0d", k), 4 - k, (k < 4) ? 1 : 0, (k == 4) ? 1 : 0);
      end
      tick();
      chk3("t3.after", 0, 0, 0);

      // 4: pause on the expiry edge
      do_load(2);
      do_start();
      tick();
      chk3("t4.one", 1, 1, 0);
      pause = 1'b1;
      tick();
      pause = 1'b0;
      chk3("t4.paused", 1, 1, 0);
      start = 1'b1;
      pause = 1'b1;
      tick();
      start = 1'b0;
      pause = 1'b0;
      chk3("t4.resume", 1, 1, 0);
      tick();
      chk3("t4.expire", 0, 0, 1);

      // 5: start with zero count, then load beats start
      do_load(0);
      do_start();
      chk3("t5.zero", 0, 0, 0);
      load = 1'b1;
      load_val = 8'd7;
      start = 1'b1;
      tick();
      load = 1'b0;
      start = 1'b0;
      chk3("t5.ldst", 7, 0, 0);
      tick();
      chk3("t5.idle", 7, 0, 0);

      // 6: reset mid-run
      do_load(9);
      do_start();
      tick();
      tick();
      tick();
      chk3("t6.run", 6, 1, 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk3("t6.rst", 0, 0, 0);
      do_start();
      chk3("t6.nostart", 0, 0, 0);

      // 7: V=1 with auto-reload gives continuous done
      auto_reload = 1'b1;
      do_load(1);
      do_start();
      for (int k = 1; k <= 3; k++) begin
         tick();
         chk3($sformatf("t7.e%0d", k), 1, 1, 1);
      end
      auto_reload = 1'b0;
      tick();
      chk3("t7.end", 0, 0, 1);
      tick();
      chk3("t7.idle", 0, 0, 0);

      // 8: all-ones load value
      do_load(255);
      do_start();
      tick();
      chk3("t8.dec", 254, 1, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
